// File: rtl/keccak_pkg.sv
// Shared keccak-side definitions: datapath width, counter width, mode codes
// and the ibytes feeder state encoding.
package keccak_pkg;

  localparam int unsigned KECCAK_W = 64;
  localparam int unsigned ILEN_W   = 11;
  localparam int unsigned OLEN_W   = 10;
  localparam int unsigned CNT_W    = 9;

  localparam logic [1:0] MODE_SHA3_256 = 2'd0;
  localparam logic [1:0] MODE_SHA3_512 = 2'd1;
  localparam logic [1:0] MODE_SHAKE128 = 2'd2;
  localparam logic [1:0] MODE_SHAKE256 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/keccak_word_fifo.sv
// Synchronous word FIFO; push while full is allowed when a pop happens in the
// same cycle, since the pop frees the slot being written.
module keccak_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/keccak_ibytes_feeder.sv
// Packs a byte stream MSB-first into 64-bit words and feeds them to the keccak
// absorb port, then holds valid with zero data until keccak reports done.
module keccak_ibytes_feeder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ILEN_W     = 11,
  parameter int unsigned OLEN_W     = 10
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_mode,
  input  logic [ILEN_W-1:0] i_cmd_ibytes_len,
  input  logic [OLEN_W-1:0] i_cmd_obytes_len,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic [1:0]        o_mode,
  output logic [ILEN_W-1:0] o_ibytes_len,
  output logic [OLEN_W-1:0] o_obytes_len,
  output logic [63:0]       o_ibytes,
  output logic              o_ibytes_valid,
  input  logic              i_ibytes_ready,
  input  logic              i_obytes_done,
  output logic              o_busy
);
  import keccak_pkg::*;

  feeder_state_t       r_state;
  feeder_state_t       w_state_nxt;
  logic                r_cmd_ready;
  logic [1:0]          r_mode;
  logic [ILEN_W-1:0]   r_ilen;
  logic [OLEN_W-1:0]   r_olen;
  logic [ILEN_W-1:0]   r_byte_cnt;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [KECCAK_W-1:0] r_pack;
  logic [CNT_W-1:0]    w_cmd_nwords;
  logic [CNT_W-1:0]    w_nwords;
  logic [KECCAK_W-1:0] w_pack_word;
  logic [KECCAK_W-1:0] w_fifo_head;
  logic [2:0]          w_k;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_cmd_acc;
  logic                w_pop;
  logic                w_push;
  logic                w_byte_acc;
  logic                w_last_byte;

  assign w_cmd_nwords = CNT_W'(i_cmd_ibytes_len[ILEN_W-1:3]) + CNT_W'(|i_cmd_ibytes_len[2:0]);
  assign w_nwords     = CNT_W'(r_ilen[ILEN_W-1:3]) + CNT_W'(|r_ilen[2:0]);

  // Byte k of the current word lands in bits [63-8k -: 8].
  assign w_k         = r_byte_cnt[2:0];
  assign w_pack_word = r_pack | (KECCAK_W'(i_byte) << {~w_k, 3'b000});
  assign w_last_byte = ((r_byte_cnt + ILEN_W'(1)) == r_ilen);
  assign w_byte_acc  = o_byte_ready && i_byte_valid;
  assign w_push      = w_byte_acc && ((w_k == 3'd7) || w_last_byte);

  assign o_cmd_ready  = r_cmd_ready;
  assign o_mode       = r_mode;
  assign o_ibytes_len = r_ilen;
  assign o_obytes_len = r_olen;
  assign o_busy       = (r_state != ST_IDLE);

  keccak_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KECCAK_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (w_push),
    .i_wdata (w_pack_word),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state plus the handshake outputs that depend on the current state.
  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_acc      = 1'b0;
    w_pop          = 1'b0;
    o_byte_ready   = 1'b0;
    o_ibytes_valid = 1'b0;
    o_ibytes       = '0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_acc = i_cmd_valid && r_cmd_ready;
        if (w_cmd_acc) w_state_nxt = (w_cmd_nwords == '0) ? ST_DRAIN : ST_LOAD;
      end
      ST_LOAD: begin
        o_ibytes_valid = !w_fifo_empty;
        o_ibytes       = w_fifo_empty ? '0 : w_fifo_head;
        w_pop          = !w_fifo_empty && i_ibytes_ready;
        o_byte_ready   = (r_byte_cnt < r_ilen) && (!w_fifo_full || w_pop);
        if (w_pop && ((r_word_cnt + CNT_W'(1)) == w_nwords)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_ibytes_valid = 1'b1;
        if (i_obytes_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, packer and counters.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cmd_ready <= 1'b0;
      r_mode      <= '0;
      r_ilen      <= '0;
      r_olen      <= '0;
      r_byte_cnt  <= '0;
      r_word_cnt  <= '0;
      r_pack      <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      if (w_cmd_acc) begin
        r_mode     <= i_cmd_mode;
        r_ilen     <= i_cmd_ibytes_len;
        r_olen     <= i_cmd_obytes_len;
        r_byte_cnt <= '0;
        r_word_cnt <= '0;
        r_pack     <= '0;
      end else if (r_state != ST_IDLE && w_state_nxt == ST_IDLE) begin
        r_mode <= '0;
        r_ilen <= '0;
        r_olen <= '0;
      end
      if (w_byte_acc) begin
        r_byte_cnt <= r_byte_cnt + ILEN_W'(1);
        r_pack     <= w_push ? '0 : w_pack_word;
      end
      if (w_pop) r_word_cnt <= r_word_cnt + CNT_W'(1);
    end
  end

endmodule
